l2_line_adapter: RTL and testbench
==================================

L2_LINE_ADAPTER -- requirements
Module: l2_line_adapter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, memory beat width in bits; beats per line = LINE_W/BURST_W = 4 by default.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port mem_read  input  1  line read request from the L2 controller; held until mem_resp.
REQ-006 SHALL have port mem_write  input  1  line write-back request from the L2 controller; held until mem_resp.
REQ-007 SHALL have port mem_address  input  32  line address from the controller; bits [4:0] are ignored.
REQ-008 SHALL have port line_i  input  LINE_W  write-back line data, stable while mem_write is high.
REQ-009 SHALL have port line_o  output  LINE_W  assembled read line.
REQ-010 SHALL have port mem_resp  output  1  one-cycle completion pulse to the controller.
REQ-011 SHALL have port pmem_read  output  1  burst read request to physical memory.
REQ-012 SHALL have port pmem_write  output  1  burst write request to physical memory.
REQ-013 SHALL have port pmem_address  output  32  burst address = {mem_address[31:5], 5'b0}.
REQ-014 SHALL have port pmem_rdata  input  BURST_W  read beat data, valid when pmem_resp is high.
REQ-015 SHALL have port pmem_wdata  output  BURST_W  current write beat.
REQ-016 SHALL have port pmem_resp  input  1  per-beat acknowledge from physical memory.

Function
REQ-017 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE.
REQ-018 IDLE SHALL transition on request, capturing the address and resetting the beat counter:
- mem_write high: latch line_i into the write buffer, go to WR_BURST.
- mem_read high and mem_write low: go to RD_BURST.
- neither: stay in IDLE.
REQ-019 When mem_read and mem_write are both high in IDLE, the write SHALL take priority.
REQ-020 RD_BURST SHALL hold pmem_read high; on each cycle with pmem_resp high, store pmem_rdata into line_o slice [k*BURST_W +: BURST_W], where k is the beat counter, and increment k.
REQ-021 WR_BURST SHALL hold pmem_write high and drive pmem_wdata = buffer slice k; on each cycle with pmem_resp high, increment k.
REQ-022 The accept of the last beat (k = 3 with pmem_resp high) SHALL move the FSM to DONE on the next edge; the beat counter SHALL wrap to 0.
REQ-023 DONE SHALL assert mem_resp for exactly one cycle with line_o fully valid, then go to IDLE unconditionally.
REQ-024 pmem_read and pmem_write SHALL be low in IDLE and DONE and SHALL never be high together.
REQ-025 pmem_resp seen in IDLE or DONE SHALL be ignored.
REQ-026 pmem_resp low mid-burst SHALL stall with no timeout, holding the counter, request, and address.
REQ-027 pmem_address SHALL remain constant from acceptance through DONE.
REQ-028 line_o SHALL hold its value until the first beat of the next read burst.
REQ-029 Minimum latency from request to mem_resp SHALL be 6 cycles: accept, 4 beats, DONE.
REQ-030 A new request SHALL be accepted in the IDLE cycle immediately after DONE, so that WRITE_BACK followed by NEW_BLOCK runs back-to-back.

Reset
REQ-031 rst high SHALL immediately force, regardless of clk:
- FSM to IDLE and beat counter to 0.
- mem_resp, pmem_read, and pmem_write to 0.
- pmem_address, line_o, and the write buffer to 0.
REQ-032 Reset asserted mid-burst SHALL abandon the transfer with no mem_resp; the next request SHALL start at beat 0.

Verification
REQ-033 Read: mem_read=1, mem_address=0x0000_1234; memory returns beats 0x11..,0x22..,0x33..,0x44.. on 4 consecutive cycles -> pmem_address=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, mem_resp one cycle, 6 cycles total.
REQ-034 Write: mem_write=1, line_i=0xDDDD..CCCC..BBBB..AAAA.. -> pmem_wdata sequence AAAA.., BBBB.., CCCC.., DDDD..; pmem_write held 4 beats; single mem_resp pulse.
REQ-035 Stalls: pmem_resp pattern 1,0,0,1,1,0,1 during a read -> exactly 4 beats captured in order, mem_resp after the 7th cycle, address unchanged throughout.
REQ-036 Priority/back-to-back: mem_read=mem_write=1 in IDLE -> write burst first; then mem_read alone the cycle after DONE -> read burst accepted with no idle gap.
REQ-037 Reset mid-burst: rst asserted asynchronously after 2 read beats -> outputs 0 immediately, no mem_resp; a following read completes normally starting at beat 0.

Source files
------------

// File: rtl/l2_line_adapter_if.sv
// L2 line adapter bus bundle.
// Controller-side line port plus memory-side burst port.
interface l2_line_adapter_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_address;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               mem_resp;
  logic               pmem_read;
  logic               pmem_write;
  logic [31:0]        pmem_address;
  logic [BURST_W-1:0] pmem_rdata;
  logic [BURST_W-1:0] pmem_wdata;
  logic               pmem_resp;

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  line_i,
    output line_o,
    output mem_resp,
    output pmem_read,
    output pmem_write,
    output pmem_address,
    input  pmem_rdata,
    output pmem_wdata,
    input  pmem_resp
  );

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output line_i,
    input  line_o,
    input  mem_resp,
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    output pmem_rdata,
    input  pmem_wdata,
    output pmem_resp
  );
endinterface

// File: rtl/l2_line_adapter.sv
// L2 line adapter: splits cache lines into memory
// bursts and assembles read bursts back into lines.
module l2_line_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input logic clk,
  input logic rst,
  l2_line_adapter_if.slave bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [KW-1:0]     r_k;
  logic [31:0]       r_addr;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_wbuf;
  logic              w_last;
  logic              w_req;
  logic              w_unused_lo;

  // Low address bits select bytes inside the line.
  assign w_unused_lo = ^bus.mem_address[4:0];

  assign w_req  = bus.mem_read | bus.mem_write;
  assign w_last = bus.pmem_resp &&
                  (r_k == KW'(BEATS - 1));

  assign bus.mem_resp     = (r_state == DONE);
  assign bus.pmem_read    = (r_state == RD_BURST);
  assign bus.pmem_write   = (r_state == WR_BURST);
  assign bus.pmem_address = r_addr;
  assign bus.line_o       = r_line;
  assign bus.pmem_wdata   =
    r_wbuf[r_k*BURST_W +: BURST_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: write wins a simultaneous request.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.mem_write)     w_next = WR_BURST;
        else if (bus.mem_read) w_next = RD_BURST;
      end
      RD_BURST: if (w_last) w_next = DONE;
      WR_BURST: if (w_last) w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Address/buffer capture, beat counter, line assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_addr <= '0;
      r_line <= '0;
      r_wbuf <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr <= {bus.mem_address[31:5], 5'b0};
            r_k    <= '0;
          end
          if (bus.mem_write) r_wbuf <= bus.line_i;
        end
        RD_BURST: begin
          if (bus.pmem_resp) begin
            r_line[r_k*BURST_W +: BURST_W] <=
              bus.pmem_rdata;
            r_k <= w_last ? '0 : r_k + KW'(1);
          end
        end
        WR_BURST: begin
          if (bus.pmem_resp)
            r_k <= w_last ? '0 : r_k + KW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_line_adapter.sv
// Testbench for l2_line_adapter.
// Scoreboard queues hold expected lines and write beats.
module tb_l2_line_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_wbeat_q[$];
  logic [255:0] last_rline = '0;

  localparam logic [255:0] RLINE = {
    64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WLINE = {
    64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

  l2_line_adapter_if #(.LINE_W(256), .BURST_W(64)) bus ();

  l2_line_adapter #(.LINE_W(256), .BURST_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_outputs(input string name);
    checks++;
    if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 ||
        bus.pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL %s: resp/rd/wr got %b%b%b required 000",
               name, bus.mem_resp, bus.pmem_read,
               bus.pmem_write);
    end
  endtask

  // One line transfer driven as controller + memory.
  task automatic xfer(input bit rd, input bit wr,
                      input logic [31:0] addr,
                      input logic [255:0] wline,
                      input logic [255:0] rline,
                      input logic [15:0] pat,
                      input int plen,
                      input int exp_cyc,
                      input string name);
    bit          is_wr = wr;
    logic [31:0] exp_addr = {addr[31:5], 5'b0};
    int          cyc = 0;
    int          bi = 0;
    int          pi = 0;
    bit          done = 0;
    bit          resp;
    logic [63:0] eb;
    logic [255:0] el;
    if (is_wr)
      for (int i = 0; i < 4; i++)
        exp_wbeat_q.push_back(wline[i*64 +: 64]);
    else
      exp_line_q.push_back(rline);
    @(negedge clk);
    idle_outputs({name, "_idle"});
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.mem_address = addr;
    bus.line_i      = wline;
    bus.pmem_resp   = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.pmem_read && bus.pmem_write) begin
        checks++;
        errors++;
        $display("FAIL %s_both: pmem_read and pmem_write high",
                 name);
      end
      if (bus.pmem_read || bus.pmem_write) begin
        checks++;
        if (bus.pmem_address !== exp_addr) begin
          errors++;
          $display("FAIL %s_addr: got %h required %h", name,
                   bus.pmem_address, exp_addr);
        end
        checks++;
        if (bus.pmem_write !== is_wr) begin
          errors++;
          $display("FAIL %s_dir: pmem_write got %b required %b",
                   name, bus.pmem_write, is_wr);
        end
        resp = (pi < plen) ? pat[pi] : 1'b1;
        pi++;
        bus.pmem_resp  = resp;
        bus.pmem_rdata = (bi < 4) ? rline[bi*64 +: 64] : '0;
        if (resp) begin
          if (is_wr && exp_wbeat_q.size() > 0) begin
            eb = exp_wbeat_q.pop_front();
            checks++;
            if (bus.pmem_wdata !== eb) begin
              errors++;
              $display("FAIL %s_wdata%0d: got %h required %h",
                       name, bi, bus.pmem_wdata, eb);
            end
          end
          bi++;
        end
      end else begin
        bus.pmem_resp = 1'b0;
        if (bus.mem_resp) begin
          done = 1;
          checks++;
          if (cyc != exp_cyc || bi != 4) begin
            errors++;
            $display("FAIL %s_lat: cycles %0d beats %0d required %0d 4",
                     name, cyc, bi, exp_cyc);
          end
          checks++;
          if (bus.pmem_address !== exp_addr) begin
            errors++;
            $display("FAIL %s_done_addr: got %h required %h",
                     name, bus.pmem_address, exp_addr);
          end
          if (!is_wr && exp_line_q.size() > 0) begin
            el = exp_line_q.pop_front();
            last_rline = el;
            checks++;
            if (bus.line_o !== el) begin
              errors++;
              $display("FAIL %s_line: got %h required %h",
                       name, bus.line_o, el);
            end
          end
          bus.mem_read  = 1'b0;
          bus.mem_write = 1'b0;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no mem_resp in 40 cycles",
               name);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.pmem_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.line_i      = '0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;
    rst = 1'b1;
    #3;
    idle_outputs("reset_ctl");
    checks++;
    if (bus.pmem_address !== 32'h0 || bus.line_o !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %h line %h required 0",
               bus.pmem_address, bus.line_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read();
    xfer(1, 0, 32'h0000_1234, '0, RLINE, 16'hFFFF, 0, 5,
         "read");
  endtask

  task automatic test_write();
    xfer(0, 1, 32'h0000_5678, WLINE, '0, 16'hFFFF, 0, 5,
         "write");
  endtask

  task automatic test_line_hold();
    checks++;
    if (bus.line_o !== last_rline) begin
      errors++;
      $display("FAIL line_hold: got %h required %h",
               bus.line_o, last_rline);
    end
  endtask

  task automatic test_stall();
    xfer(1, 0, 32'hABCD_EF9F, '0, ~RLINE, 16'b1011001, 7, 8,
         "stall");
  endtask

  task automatic test_back_to_back();
    xfer(1, 1, 32'h0000_2040, WLINE, '0, 16'hFFFF, 0, 5,
         "prio_wr");
    xfer(1, 0, 32'h0000_3060, '0, RLINE, 16'hFFFF, 0, 5,
         "b2b_rd");
  endtask

  task automatic test_idle_resp();
    logic [255:0] rl;
    bus.pmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_outputs("idle_resp");
    end
    bus.pmem_resp = 1'b0;
    rl = {$urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom};
    xfer(1, 0, 32'h8000_0000 | $urandom, '0, rl,
         16'hFFFF, 0, 5, "idle_rd");
  endtask

  task automatic test_reset_mid_burst();
    int beats = 0;
    int n = 0;
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_7777;
    while (beats < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.pmem_read) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 64'h5A5A_5A5A_0000_0000 | 64'(beats);
        beats++;
      end
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    idle_outputs("rst_mid_ctl");
    checks++;
    if (bus.pmem_address !== 32'h0 || bus.line_o !== '0) begin
      errors++;
      $display("FAIL rst_mid_data: addr %h line %h required 0",
               bus.pmem_address, bus.line_o);
    end
    bus.mem_read  = 1'b0;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_outputs("rst_mid_quiet");
    end
    xfer(1, 0, 32'h0000_9999, '0, RLINE, 16'hFFFF, 0, 5,
         "rst_rd");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_line_hold();
    test_stall();
    test_back_to_back();
    test_idle_resp();
    test_reset_mid_burst();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
